// File: rtl/j_scoreboard_if.sv
// Issue/writeback bundle between the issue stage and the load/divide scoreboard.
// The master modport belongs to the issue stage and the slave modport belongs to the scoreboard.
interface j_scoreboard_if;
    logic       issue_ld;
    logic       issue_div;
    logic [5:0] issue_dst;
    logic [5:0] src_a;
    logic [5:0] src_b;
    logic       src_a_use;
    logic       src_b_use;
    logic       dst_use;
    logic       ld_done;
    logic       stall;
    logic       ld_pend;
    logic       div_busy;
    logic       div_wb;
    logic [5:0] div_wb_dst;

    modport master (
        output issue_ld, issue_div, issue_dst, src_a, src_b,
               src_a_use, src_b_use, dst_use, ld_done,
        input  stall, ld_pend, div_busy, div_wb, div_wb_dst
    );

    modport slave (
        input  issue_ld, issue_div, issue_dst, src_a, src_b,
               src_a_use, src_b_use, dst_use, ld_done,
        output stall, ld_pend, div_busy, div_wb, div_wb_dst
    );
endinterface

// File: rtl/j_scoreboard.sv
// Two-entry hazard scoreboard: one outstanding external load (L) and one divide (D)
// with a fixed-latency down-counter. It generates a combinational issue stall.
module j_scoreboard #(
    parameter int unsigned DIV_CYCLES = 16
) (
    input  logic          sys_clk,
    input  logic          resetl,
    j_scoreboard_if.slave sb
);

    logic       l_valid;
    logic [5:0] l_dst;
    logic       d_valid;
    logic [5:0] d_dst;
    logic [5:0] d_cnt;

    logic l_ret, d_ret, l_live, d_live;
    logic a_hit, b_hit, w_hit;
    logic stall_c, ld_acc, div_acc;

    // A retiring entry no longer blocks anything, so writeback and issue can overlap.
    assign sb.div_wb = d_valid && (d_cnt == 6'd1);
    assign d_ret     = sb.div_wb;
    assign l_ret     = sb.ld_done && l_valid;
    assign l_live    = l_valid && !l_ret;
    assign d_live    = d_valid && !d_ret;

    always_comb begin
        a_hit = (l_live && (l_dst == sb.src_a))     || (d_live && (d_dst == sb.src_a));
        b_hit = (l_live && (l_dst == sb.src_b))     || (d_live && (d_dst == sb.src_b));
        w_hit = (l_live && (l_dst == sb.issue_dst)) || (d_live && (d_dst == sb.issue_dst));
        stall_c = (sb.src_a_use && a_hit)
               || (sb.src_b_use && b_hit)
               || (sb.dst_use   && w_hit)
               || (sb.issue_ld  && l_live)
               || (sb.issue_div && d_live)
               || (sb.issue_ld  && sb.issue_div);
    end

    assign sb.stall = stall_c;
    assign ld_acc   = sb.issue_ld  && !sb.issue_div && !stall_c;
    assign div_acc  = sb.issue_div && !sb.issue_ld  && !stall_c;

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            l_valid <= 1'b0;
            l_dst   <= '0;
        end else if (ld_acc) begin
            l_valid <= 1'b1;
            l_dst   <= sb.issue_dst;
        end else if (l_ret) begin
            l_valid <= 1'b0;
        end
    end

    // d_dst is kept after retirement so that div_wb_dst holds the last divide destination.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            d_valid <= 1'b0;
            d_dst   <= '0;
            d_cnt   <= '0;
        end else if (div_acc) begin
            d_valid <= 1'b1;
            d_dst   <= sb.issue_dst;
            d_cnt   <= 6'(DIV_CYCLES);
        end else if (d_ret) begin
            d_valid <= 1'b0;
            d_cnt   <= '0;
        end else if (d_valid && (d_cnt > 6'd1)) begin
            d_cnt   <= d_cnt - 6'd1;
        end
    end

    assign sb.ld_pend    = l_valid;
    assign sb.div_busy   = d_valid;
    assign sb.div_wb_dst = d_dst;

endmodule

// File: tb/tb_j_scoreboard.sv
// Directed self-checking bench for j_scoreboard (DIV_CYCLES=16).
module tb_j_scoreboard;

    logic sys_clk = 1'b0;
    logic resetl;
    int unsigned tests = 0;
    int unsigned fails = 0;

    j_scoreboard_if bus ();

    j_scoreboard #(.DIV_CYCLES(16)) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .sb      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_ld  = 1'b0;
        bus.issue_div = 1'b0;
        bus.issue_dst = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.src_a_use = 1'b0;
        bus.src_b_use = 1'b0;
        bus.dst_use   = 1'b0;
        bus.ld_done   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetl = 1'b0;
        idle();
        #2;
        check("rst_ld_pend", {7'b0, bus.ld_pend}, 8'h0);
        check("rst_div_busy", {7'b0, bus.div_busy}, 8'h0);
        check("rst_div_wb", {7'b0, bus.div_wb}, 8'h0);
        check("rst_stall", {7'b0, bus.stall}, 8'h0);
        check("rst_wb_dst", {2'b0, bus.div_wb_dst}, 8'h0);
        tick(); tick();
        resetl = 1'b1;
        tick();

        // Load RAW hazard
        bus.issue_ld = 1'b1; bus.issue_dst = 6'h05; bus.dst_use = 1'b1;
        #1 check("raw_accept_stall", {7'b0, bus.stall}, 8'h0);
        tick();
        idle();
        bus.src_a = 6'h05; bus.src_a_use = 1'b1;
        #1 check("raw_stall", {7'b0, bus.stall}, 8'h1);
        check("raw_ld_pend", {7'b0, bus.ld_pend}, 8'h1);
        bus.ld_done = 1'b1;
        #1 check("raw_done_stall", {7'b0, bus.stall}, 8'h0);
        tick();
        bus.ld_done = 1'b0;
        #1 check("raw_ld_cleared", {7'b0, bus.ld_pend}, 8'h0);
        check("raw_after_stall", {7'b0, bus.stall}, 8'h0);

        // Bank bit distinction and WAW
        idle();
        bus.issue_ld = 1'b1; bus.issue_dst = 6'h03;
        tick();
        idle();
        bus.src_b = 6'h23; bus.src_b_use = 1'b1;
        #1 check("bank_other", {7'b0, bus.stall}, 8'h0);
        bus.src_b = 6'h03;
        #1 check("bank_same", {7'b0, bus.stall}, 8'h1);
        idle();
        bus.issue_dst = 6'h03; bus.dst_use = 1'b1;
        #1 check("waw_stall", {7'b0, bus.stall}, 8'h1);
        bus.dst_use = 1'b0; bus.src_a = 6'h03; bus.src_a_use = 1'b0;
        #1 check("unused_src", {7'b0, bus.stall}, 8'h0);

        // New load accepted while the old one retires
        idle();
        bus.issue_ld = 1'b1; bus.issue_dst = 6'h07; bus.ld_done = 1'b1;
        #1 check("ld_overlap_stall", {7'b0, bus.stall}, 8'h0);
        tick();
        idle();
        #1 check("ld_overlap_pend", {7'b0, bus.ld_pend}, 8'h1);
        bus.src_a = 6'h07; bus.src_a_use = 1'b1;
        #1 check("ld_overlap_new", {7'b0, bus.stall}, 8'h1);
        bus.src_a = 6'h03;
        #1 check("ld_overlap_old", {7'b0, bus.stall}, 8'h0);
        bus.issue_ld = 1'b1; bus.src_a_use = 1'b0;
        #1 check("ld_second_stall", {7'b0, bus.stall}, 8'h1);
        idle();
        bus.ld_done = 1'b1;
        tick();
        idle();
        #1 check("ld_retired", {7'b0, bus.ld_pend}, 8'h0);
        bus.ld_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        #1 check("ld_done_ignored", {7'b0, bus.ld_pend}, 8'h0);

        // Illegal load and divide issued together
        bus.issue_ld = 1'b1; bus.issue_div = 1'b1; bus.issue_dst = 6'h11;
        #1 check("illegal_stall", {7'b0, bus.stall}, 8'h1);
        tick();
        idle();
        #1 check("illegal_no_ld", {7'b0, bus.ld_pend}, 8'h0);
        check("illegal_no_div", {7'b0, bus.div_busy}, 8'h0);

        // Single divide latency
        bus.issue_div = 1'b1; bus.issue_dst = 6'h23;
        #1 check("div_accept_stall", {7'b0, bus.stall}, 8'h0);
        tick();
        idle();
        for (int c = 1; c <= 16; c++) begin
            #1;
            check($sformatf("div_busy_c%0d", c), {7'b0, bus.div_busy}, 8'h1);
            check($sformatf("div_wb_c%0d", c), {7'b0, bus.div_wb}, {7'b0, c == 16});
            if (c == 16) check("div_wb_dst", {2'b0, bus.div_wb_dst}, 8'h23);
            tick();
        end
        #1 check("div_done_busy", {7'b0, bus.div_busy}, 8'h0);
        check("div_done_wb", {7'b0, bus.div_wb}, 8'h0);

        // Back-to-back divides
        bus.issue_div = 1'b1; bus.issue_dst = 6'h23;
        tick();
        idle();
        for (int c = 1; c <= 16; c++) begin
            if (c >= 2) begin
                bus.issue_div = 1'b1; bus.issue_dst = 6'h10;
            end
            #1;
            check($sformatf("b2b_busy_c%0d", c), {7'b0, bus.div_busy}, 8'h1);
            check($sformatf("b2b_wb_c%0d", c), {7'b0, bus.div_wb}, {7'b0, c == 16});
            if (c >= 2) check($sformatf("b2b_stall_c%0d", c), {7'b0, bus.stall}, {7'b0, c < 16});
            if (c == 16) check("b2b_wb_dst1", {2'b0, bus.div_wb_dst}, 8'h23);
            tick();
        end
        idle();
        for (int c = 17; c <= 32; c++) begin
            #1;
            check($sformatf("b2b_busy_c%0d", c), {7'b0, bus.div_busy}, 8'h1);
            check($sformatf("b2b_wb_c%0d", c), {7'b0, bus.div_wb}, {7'b0, c == 32});
            if (c == 32) check("b2b_wb_dst2", {2'b0, bus.div_wb_dst}, 8'h10);
            tick();
        end
        #1 check("b2b_done_busy", {7'b0, bus.div_busy}, 8'h0);

        // Reset mid-operation
        bus.issue_ld = 1'b1; bus.issue_dst = 6'h02;
        tick();
        idle();
        bus.issue_div = 1'b1; bus.issue_dst = 6'h01;
        tick();
        idle();
        tick(); tick(); tick(); tick();
        check("pre_rst_ld", {7'b0, bus.ld_pend}, 8'h1);
        check("pre_rst_div", {7'b0, bus.div_busy}, 8'h1);
        resetl = 1'b0;
        #1 check("midrst_ld_pend", {7'b0, bus.ld_pend}, 8'h0);
        check("midrst_div_busy", {7'b0, bus.div_busy}, 8'h0);
        check("midrst_wb_dst", {2'b0, bus.div_wb_dst}, 8'h0);
        for (int c = 6; c <= 20; c++) begin
            tick();
            if (c == 8) resetl = 1'b1;
            #1;
            check($sformatf("midrst_wb_c%0d", c), {7'b0, bus.div_wb}, 8'h0);
            check($sformatf("midrst_busy_c%0d", c), {7'b0, bus.div_busy}, 8'h0);
        end

        // First accept immediately after reset release
        resetl = 1'b0;
        tick();
        resetl = 1'b1;
        bus.issue_div = 1'b1; bus.issue_dst = 6'h05;
        #1 check("post_rst_stall", {7'b0, bus.stall}, 8'h0);
        tick();
        idle();
        #1 check("post_rst_busy", {7'b0, bus.div_busy}, 8'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/j_scoreboard.md
J_SCOREBOARD -- requirements
Module: j_scoreboard

Interface
REQ-001 Parameter: DIV_CYCLES, default 16, divide latency in cycles (legal range 2..63).
REQ-002 Port: sys_clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: resetl  in  1  reset, asynchronous, active-low.
REQ-004 Port: issue_ld  in  1  issuing instruction is an external load writing issue_dst.
REQ-005 Port: issue_div  in  1  issuing instruction is a divide writing issue_dst.
REQ-006 Port: issue_dst  in  6  destination register index (5-bit register plus bank bit).
REQ-007 Port: src_a / src_b  in  6 each  source operand register indices of the issuing instruction.
REQ-008 Port: src_a_use / src_b_use  in  1 each  the corresponding source is read.
REQ-009 Port: dst_use  in  1  the issuing instruction writes issue_dst (WAW check).
REQ-010 Port: ld_done  in  1  single-cycle pulse: the pending load writes back this cycle.
REQ-011 Port: stall  out  1  combinational; issue must be held.
REQ-012 Port: ld_pend / div_busy  out  1 each  load or divide entry valid.
REQ-013 Port: div_wb  out  1  divide writes back this cycle.
REQ-014 Port: div_wb_dst  out  6  register index for div_wb; holds last divide dst otherwise.

Function
REQ-015 The block SHALL hold two entries, L (load) and D (divide), each a valid bit plus a 6-bit index; D also holds a 6-bit down-counter.
REQ-016 Match: a 6-bit index SHALL match an entry when all six bits are equal and the entry is valid and not retiring this cycle.
REQ-017 Retiring: L retires in any cycle with ld_done=1 and L valid; D retires in any cycle with div_wb=1.
REQ-018 stall SHALL be 1 when (src_a_use and src_a matches L or D), or (src_b_use and src_b matches), or (dst_use and issue_dst matches), or (issue_ld and L valid and not retiring), or (issue_div and D valid and not retiring), or (issue_ld and issue_div both 1).
REQ-019 Accept: a load is accepted when issue_ld=1, issue_div=0, stall=0; a divide is accepted when issue_div=1, issue_ld=0, stall=0; stall is meaningful only while issue_ld or issue_div or any *_use is 1.
REQ-020 On load accept, L SHALL become valid with issue_dst at the next edge; accept and ld_done in the same cycle leaves L valid holding the new index.
REQ-021 On divide accept, D SHALL become valid with issue_dst and counter=DIV_CYCLES at the next edge.
REQ-022 While D is valid, the counter SHALL decrement by 1 per cycle; div_wb=1 exactly in the cycle counter==1, and D clears at the following edge unless a new divide is accepted in that cycle.
REQ-023 Latency: divide accepted at edge 0 gives div_busy=1 in cycles 1..DIV_CYCLES and div_wb=1 in cycle DIV_CYCLES only.
REQ-024 div_wb_dst SHALL equal D's index whenever div_wb=1.
REQ-025 ld_done with L invalid SHALL be ignored (no state change).
REQ-026 Counter SHALL never wrap; it does not decrement below 1 while D is valid.

Reset
REQ-027 resetl=0 SHALL immediately clear L, D, counter and div_wb_dst to 0; outputs ld_pend=0, div_busy=0, div_wb=0.
REQ-028 Reset asserted mid-divide SHALL abort it with no div_wb pulse; first accept is possible in the first cycle after resetl rises.
REQ-029 stall SHALL be purely combinational from inputs and entry state; during reset with all issue/use inputs 0 it is 0.

Verification
REQ-030 Load RAW: accept load dst=0x05; next cycle src_a=0x05, src_a_use=1 -> stall=1; assert ld_done -> stall=0 that same cycle; next cycle ld_pend=0.
REQ-031 Divide latency (DIV_CYCLES=16): divide dst=0x23 accepted at edge 0 -> div_busy=1 cycles 1..16, div_wb=1 and div_wb_dst=0x23 only in cycle 16, div_busy=0 in cycle 17.
REQ-032 Bank distinction: pending load dst=0x03; src_b=0x23, src_b_use=1 -> stall=0; src_b=0x03 -> stall=1.
REQ-033 Back-to-back: issue_div dst=0x10 held from cycle 2 while D busy -> stall=1 until cycle 16 (div_wb), accepted there; div_busy stays 1 continuously, new div_wb in cycle 32.
REQ-034 Reset mid-operation: divide accepted and load pending, resetl=0 at cycle 5 -> ld_pend=0, div_busy=0 immediately, no div_wb through cycle 20.
REQ-035 Illegal issue: issue_ld=1 and issue_div=1 together -> stall=1, neither entry changes.
